// File: rtl/reg_write_arbiter.sv
// Two-requester round-robin arbiter that owns a shared WIDTH-bit register.
// Registered one-hot grants, tenure capped at HOLD_MAX cycles under contention.
module reg_write_arbiter #(
   parameter int WIDTH    = 4,
   parameter int HOLD_MAX = 4
) (
   input  logic             clock,
   input  logic             reset_,
   input  logic             req0,
   input  logic             req1,
   input  logic             we0,
   input  logic             we1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_
);

   localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [CW-1:0]    r_holdCnt;
   logic [CW-1:0]    w_nextHold;
   logic             r_last;
   logic             w_nextLast;
   logic [WIDTH-1:0] r_q;
   logic             w_holdDone;

   assign w_holdDone = (r_holdCnt == HOLD_LAST);

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         r_state   <= IDLE;
         r_holdCnt <= '0;
         r_last    <= 1'b1;
      end else begin
         r_state   <= w_nextState;
         r_holdCnt <= w_nextHold;
         r_last    <= w_nextLast;
      end
   end

   // Writes are honoured only from the current owner, including its final grant cycle.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         r_q <= '0;
      end else if ((r_state == G0) && we0) begin
         r_q <= data0;
      end else if ((r_state == G1) && we1) begin
         r_q <= data1;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (req0 && (!req1 || r_last))
               w_nextState = G0;
            else if (req1)
               w_nextState = G1;
         end
         G0: begin
            if (!req0)
               w_nextState = req1 ? G1 : IDLE;
            else if (req1 && w_holdDone)
               w_nextState = G1;
         end
         G1: begin
            if (!req1)
               w_nextState = req0 ? G0 : IDLE;
            else if (req0 && w_holdDone)
               w_nextState = G0;
         end
         default: w_nextState = IDLE;
      endcase

      w_nextLast = r_last;
      if (w_nextState != r_state) begin
         if (w_nextState == G0)
            w_nextLast = 1'b0;
         else if (w_nextState == G1)
            w_nextLast = 1'b1;
      end

      // Counter restarts on every entry and saturates so an idle rival never forces a handoff.
      w_nextHold = r_holdCnt;
      if ((w_nextState == IDLE) || (w_nextState != r_state))
         w_nextHold = '0;
      else if (!w_holdDone)
         w_nextHold = r_holdCnt + 1'b1;
   end

   always_comb begin
      gnt0 = (r_state == G0);
      gnt1 = (r_state == G1);
      busy = (r_state == G0) || (r_state == G1);
      q    = r_q;
      q_   = ~r_q;
   end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Two-requester round-robin arbiter that owns a shared WIDTH-bit storage register built from edge-triggered D flip-flops. It grants write access to one requester at a time, with a registered grant handshake. It bounds tenure to HOLD_MAX cycles when the other side is waiting. It sits between two producer blocks and the shared state register, and exposes true and complemented register outputs.

Parameters:
WIDTH, 4, bit width of shared register and data inputs
HOLD_MAX, 4, max consecutive grant cycles while the other requester waits (>=1)

Ports:
clock  input  1  rising-edge clock
reset_  input  1  asynchronous active-low reset
req0  input  1  requester 0 wants access (level, held until done)
req1  input  1  requester 1 wants access
we0  input  1  requester 0 write strobe, honoured only while gnt0=1
we1  input  1  requester 1 write strobe, honoured only while gnt1=1
data0  input  WIDTH  requester 0 write data
data1  input  WIDTH  requester 1 write data
gnt0  output  1  registered grant to requester 0
gnt1  output  1  registered grant to requester 1
busy  output  1  gnt0|gnt1
q  output  WIDTH  shared register contents
q_  output  WIDTH  bitwise complement of q, always ~q

Behaviour:
- Reset is asynchronous and active-low on reset_. While reset_=0: state=IDLE, gnt0=gnt1=0, busy=0, q=0, q_=all ones, hold_cnt=0, last=1 (requester 0 wins first tie). Reset mid-grant drops the grant immediately and aborts any write in that cycle.
- States: IDLE, G0, G1. gnt0=1 exactly in G0 and gnt1=1 exactly in G1. Grants are one-hot or zero and never both 1.
- IDLE: at the edge, req0 only -> G0. req1 only -> G1. Both -> grant the requester != last. Neither -> stay. Grant latency is 1 cycle: req sampled high at edge N gives gnt high after edge N.
- Gx (x=owner, y=other), evaluated at each edge:
  - reqx=0 -> release. Go to Gy if reqy=1, else IDLE. Handoff has no idle cycle.
  - reqx=1, reqy=1, hold_cnt=HOLD_MAX-1 -> preempt to Gy.
  - Otherwise stay.
- hold_cnt clears to 0 on entry to any Gx and increments each cycle in Gx. It saturates at HOLD_MAX-1, so an uncontended owner keeps the grant indefinitely. When the other side then requests, that requester waits at most 1 further cycle.
- last is updated to x on entry to Gx.
- Write: at an edge where gnt0=1 and we0=1, q<=data0. Where gnt1=1 and we1=1, q<=data1. Otherwise q holds. The write occurs in the same cycle as a release or preempt edge if we is high in that last grant cycle. weY without gntY is ignored silently. q_ is updated together with q.
- A requester that deasserts req before being granted is dropped with no grant issued.

Test Plan:
- Reset: hold reset_=0 mid-run with gnt1=1 and q=4'hA -> gnt0=gnt1=0, q=4'h0, q_=4'hF immediately, with no clock edge needed.
- Single grant and write: req0=1 at cycle 0; we0=1 with data0=4'h5 in cycle 1 -> gnt0=1 from cycle 1, q=4'h5 from cycle 2, q_=4'hA. Drop req0 in cycle 3 -> gnt0=0 from cycle 4.
- Tie after reset: req0=req1=1 in IDLE -> gnt0 first. After req0 drops -> gnt1 on the next cycle, with no IDLE gap.
- Preemption with HOLD_MAX=4: G0 entered at cycle 1, req0 and req1 held high -> gnt0 in cycles 1-4, gnt1 from cycle 5. Held requests then alternate every 4 cycles.
- Ungranted write: G0 active, we1=1 with data1=4'h3 -> q unchanged. Same-cycle we0 with data0=4'h9 -> q=4'h9.
- Uncontended saturation: req0 held for 10 cycles alone -> gnt0 stays 1 throughout. req1 rises in cycle 10 -> gnt1=1 by cycle 11.
